vga_timing_gen: RTL and testbench

Raster timing generator for the DE10-Standard VGA path. It produces the `hValue`/`vValue` pixel coordinates, the `activeVideo` qualifier and the `VGA_HS`/`VGA_VS` syncs that the pattern generator consumes. It also drives the ADV7123 DAC control pins. The default timing is 640x480 @ 60 Hz on a 25 MHz pixel rate, with an optional pixel enable for running from a faster system clock.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 59 +++++
 rtl/vga_timing_gen.sv | 84 ++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;

    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    // Level driven on a sync pin while the sync interval is in progress
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    localparam int MAX_TOTAL = 65535;

    function automatic int axis_total(int s, int b, int a, int f);
        return s + b + a + f;
    endfunction

    function automatic int active_start(int s, int b);
        return s + b;
    endfunction

    function automatic int active_end(int s, int b, int a);
        return s + b + a - 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/active decode.
// Decodes use the next-state count so they line up with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   SYNC     = DEF_H_SYNC,
    parameter int   BP       = DEF_H_BP,
    parameter int   ACTIVE   = DEF_H_ACTIVE,
    parameter int   FP       = DEF_H_FP,
    parameter logic SYNC_POL = POL_ACTIVE_LOW
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count,
    output logic [15:0] count_next,
    output logic        sync,
    output logic        active,
    output logic        wrap
);

    localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);

    if (TOTAL > MAX_TOTAL) begin : g_total_too_big
        $error("vga_axis_counter: axis total exceeds 65535");
    end

    localparam logic [15:0] LAST     = 16'(TOTAL - 1);
    localparam logic [15:0] SYNC_END = 16'(SYNC);
    localparam logic [15:0] A_START  = 16'(active_start(SYNC, BP));
    localparam logic [15:0] A_END    = 16'(active_end(SYNC, BP, ACTIVE));

    assign wrap = inc & (count == LAST);

    // Next count: reset wins, then wrap, then plain increment
    always_comb begin
        count_next = count;
        if (reset)
            count_next = '0;
        else if (wrap)
            count_next = '0;
        else if (inc)
            count_next = count + 16'd1;
    end

    // Register the count together with its decodes
    always_ff @(posedge clkin) begin
        if (reset) begin
            count  <= '0;
            sync   <= SYNC_POL;
            active <= 1'b0;
        end else begin
            count  <= count_next;
            sync   <= (count_next < SYNC_END) ? SYNC_POL : ~SYNC_POL;
            active <= (count_next >= A_START) && (count_next <= A_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: coordinates, syncs, blanking, frame pulse.
// Also drives the ADV7123 DAC control pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter logic SYNC_POL = POL_ACTIVE_LOW
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        pixEn,
    output logic [15:0] hValue,
    output logic [15:0] vValue,
    output logic        activeVideo,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frameStart
);

    logic [15:0] h_next;
    logic [15:0] v_next;
    logic        h_active;
    logic        v_active;
    logic        h_wrap;
    logic        v_wrap;

    vga_axis_counter #(
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .ACTIVE  (H_ACTIVE),
        .FP      (H_FP),
        .SYNC_POL(SYNC_POL)
    ) u_h (
        .clkin     (clkin),
        .reset     (reset),
        .inc       (pixEn),
        .count     (hValue),
        .count_next(h_next),
        .sync      (VGA_HS),
        .active    (h_active),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .ACTIVE  (V_ACTIVE),
        .FP      (V_FP),
        .SYNC_POL(SYNC_POL)
    ) u_v (
        .clkin     (clkin),
        .reset     (reset),
        .inc       (h_wrap),
        .count     (vValue),
        .count_next(v_next),
        .sync      (VGA_VS),
        .active    (v_active),
        .wrap      (v_wrap)
    );

    assign activeVideo = h_active & v_active;
    assign VGA_BLANK_N = activeVideo;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = clkin & pixEn;

    // Pulse only when the raster wraps into (0,0), never on reset
    always_ff @(posedge clkin) begin
        if (reset)
            frameStart <= 1'b0;
        else
            frameStart <= v_wrap && (h_next == '0) && (v_next == '0);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster.
// H: 3/2/6/2 (13 total), V: 2/1/3/1 (7 total), frame = 91 pixels.
module tb_vga_timing_gen;

    localparam int HS = 3, HB = 2, HA = 6, HF = 2;
    localparam int VS = 2, VB = 1, VA = 3, VF = 1;
    localparam int HT = 13, VT = 7;
    localparam int HAS = 5, HAE = 10;
    localparam int VAS = 3, VAE = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixEn = 1'b1;
    logic [15:0] hValue, vValue;
    logic        activeVideo, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic        VGA_SYNC_N, VGA_CLK, frameStart;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .SYNC_POL(1'b0)
    ) dut (
        .clkin      (clk),
        .reset      (reset),
        .pixEn      (pixEn),
        .hValue     (hValue),
        .vValue     (vValue),
        .activeVideo(activeVideo),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_CLK    (VGA_CLK),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] h, v;
        logic        hs, vs, act, fs, vclk;
        bit          rst;
        int          gap, actn;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    int mh = 0, mv = 0;
    int cur_gap = 91, cur_actn = 18;

    task automatic step(input logic r, input logic pe);
        exp_t e;
        logic fs;
        @(negedge clk);
        reset = r;
        pixEn = pe;
        fs = 1'b0;
        if (r) begin
            mh = 0;
            mv = 0;
        end else if (pe) begin
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    fs = 1'b1;
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        e.h    = 16'(mh);
        e.v    = 16'(mv);
        e.hs   = (mh < HS) ? 1'b0 : 1'b1;
        e.vs   = (mv < VS) ? 1'b0 : 1'b1;
        e.act  = (mh >= HAS && mh <= HAE && mv >= VAS && mv <= VAE);
        e.fs   = fs;
        e.vclk = pe;
        e.rst  = r;
        e.gap  = cur_gap;
        e.actn = cur_actn;
        q.push_back(e);
    endtask

    // Monitor: pop one expectation per edge and compare
    initial begin : monitor
        exp_t e;
        int cyc = 0;
        int fs_last = -1;
        int act_cnt = 0;
        logic [40:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                got  = {hValue, vValue, VGA_HS, VGA_VS, activeVideo,
                        VGA_BLANK_N, VGA_SYNC_N, frameStart, VGA_CLK,
                        2'b00};
                want = {e.h, e.v, e.hs, e.vs, e.act,
                        e.act, 1'b0, e.fs, e.vclk, 2'b00};
                n_total++;
                if (got === want) n_pass++;
                else
                    $display("FAIL cyc%0d: got h=%0d v=%0d hs=%b vs=%b act=%b blk=%b sn=%b fs=%b vclk=%b, want h=%0d v=%0d hs=%b vs=%b act=%b fs=%b vclk=%b",
                             cyc, hValue, vValue, VGA_HS, VGA_VS,
                             activeVideo, VGA_BLANK_N, VGA_SYNC_N,
                             frameStart, VGA_CLK, e.h, e.v, e.hs,
                             e.vs, e.act, e.fs, e.vclk);
                if (e.rst) begin
                    fs_last = -1;
                    act_cnt = 0;
                end else begin
                    if (activeVideo === 1'b1) act_cnt++;
                    if (frameStart === 1'b1) begin
                        if (fs_last >= 0) begin
                            n_total++;
                            if (cyc - fs_last == e.gap) n_pass++;
                            else
                                $display("FAIL frame_gap: got %0d want %0d",
                                         cyc - fs_last, e.gap);
                            n_total++;
                            if (act_cnt == e.actn) n_pass++;
                            else
                                $display("FAIL active_count: got %0d want %0d",
                                         act_cnt, e.actn);
                        end
                        fs_last = cyc;
                        act_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

        cur_gap = 91; cur_actn = 18;
        for (int i = 0; i < 280; i++) step(1'b0, 1'b1);

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        cur_gap = 182; cur_actn = 36;
        for (int i = 0; i < 570; i++) step(1'b0, (i % 2) == 0);

        cur_gap = 91; cur_actn = 18;
        step(1'b1, 1'b1);
        k = 0;
        while (!(mh == 7 && mv == 4) && k < 200) begin
            step(1'b0, 1'b1);
            k++;
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 120; i++) step(1'b0, 1'b1);

        k = 0;
        while (!(mh == HT - 1 && mv == VT - 1) && k < 200) begin
            step(1'b0, 1'b1);
            k++;
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        k = 0;
        while (q.size() > 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #2;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
